// File: rtl/soc_system_pio_pkg.sv
// Shared constants for the HPS-to-fabric PIO register map (input and output ports).
package soc_system_pio_pkg;

  typedef logic [1:0]  pio_addr_t;
  typedef logic [31:0] pio_word_t;

  localparam pio_addr_t ADDR_DATA     = 2'd0;
  localparam pio_addr_t ADDR_RSVD     = 2'd1;
  localparam pio_addr_t ADDR_MASK     = 2'd2;
  localparam pio_addr_t ADDR_CAPTURE  = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Avalon-MM write strobe qualification.
  function automatic logic bus_write_en(input logic chipselect, input logic write_n);
    return chipselect && !write_n;
  endfunction

endpackage

// File: rtl/soc_system_in_capture_if.sv
// Avalon-MM slave bus bundle for the input capture PIO.
interface soc_system_in_capture_if;
  import soc_system_pio_pkg::*;

  pio_addr_t address;
  logic      chipselect;
  logic      write_n;
  pio_word_t writedata;
  pio_word_t readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/soc_system_sync_edge.sv
// Input synchronizer, previous-value flop and arming counter; emits armed edge pulses.
module soc_system_sync_edge
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edge_hit
);

  // Edges are suppressed until the synchronizer and prev flop hold real input data.
  localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] s [SYNC_STAGES];
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] raw_edge;
  logic [2:0]       arm_cnt;
  logic             armed;

  assign sync  = s[SYNC_STAGES-1];
  assign armed = (arm_cnt == ARM_CYCLES);

  // Synchronizer chain, previous-value flop and saturating arm counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) s[k] <= '0;
      prev    <= '0;
      arm_cnt <= '0;
    end else begin
      s[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) s[k] <= s[k-1];
      prev <= sync;
      if (!armed) arm_cnt <= arm_cnt + 3'd1;
    end
  end

  // Edge selection by EDGE_TYPE, gated by the arm state.
  always_comb begin
    rise = sync & ~prev;
    fall = ~sync & prev;
    case (EDGE_TYPE)
      EDGE_FALL: raw_edge = fall;
      EDGE_ANY:  raw_edge = rise | fall;
      default:   raw_edge = rise;
    endcase
    edge_hit = armed ? raw_edge : '0;
  end

endmodule

// File: rtl/soc_system_in_capture.sv
// Avalon-MM input PIO: DATA / MASK / CAPTURE (W1C) registers and a level interrupt.
module soc_system_in_capture
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  soc_system_in_capture_if.slave  bus,
  input  logic [WIDTH-1:0]        in_port,
  output logic                    irq
);

  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wdata;
  logic             wr_en;

  soc_system_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .sync     (sync),
    .edge_hit (edge_hit)
  );

  assign wr_en = bus_write_en(bus.chipselect, bus.write_n);
  assign wdata = bus.writedata[WIDTH-1:0];
  assign clr   = (wr_en && bus.address == ADDR_CAPTURE) ? wdata : '0;

  // Upper write-data bits have no storage behind them.
  if (WIDTH < 32) begin : g_unused_wdata
    logic [31-WIDTH:0] unused_wdata_hi;
    assign unused_wdata_hi = bus.writedata[31:WIDTH];
  end

  // MASK write and sticky CAPTURE update; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask <= '0;
      cap  <= '0;
    end else begin
      if (wr_en && bus.address == ADDR_MASK) mask <= wdata;
      cap <= (cap & ~clr) | edge_hit;
    end
  end

  assign irq = |(cap & mask);

  // Zero-wait-state read mux, zero-extended above WIDTH.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:    bus.readdata[WIDTH-1:0] = sync;
      ADDR_MASK:    bus.readdata[WIDTH-1:0] = mask;
      ADDR_CAPTURE: bus.readdata[WIDTH-1:0] = cap;
      default:      bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_in_capture.sv
// Scoreboard bench: rising-edge (dut0) and any-edge (dut2) instances share stimulus.
module tb_soc_system_in_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0]  in_port = '0;
  logic        irq0;
  logic        irq2;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] obs_q[$];

  soc_system_in_capture_if bus0();
  soc_system_in_capture_if bus2();

  assign bus0.address    = address;
  assign bus0.chipselect = chipselect;
  assign bus0.write_n    = write_n;
  assign bus0.writedata  = writedata;
  assign bus2.address    = address;
  assign bus2.chipselect = chipselect;
  assign bus2.write_n    = write_n;
  assign bus2.writedata  = writedata;

  soc_system_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .in_port(in_port), .irq(irq0));

  soc_system_in_capture #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .in_port(in_port), .irq(irq2));

  always #5 clk = ~clk;

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d0, output logic [31:0] d2);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d0 = bus0.readdata; d2 = bus2.readdata;
    chipselect = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string n, input logic [31:0] ex, input logic [31:0] ob);
    exp_q.push_back(exp_t'{name: n, val: ex});
    obs_q.push_back(ob);
  endtask

  task automatic test_reset;
    logic [31:0] d0, d2, o;
    exp_t e;
    reset_n = 1'b0; in_port = 8'hFF;
    step(3);
    bus_read(2'd0, d0, d2); sb_push("rst_hold_data", 0, d0);
    bus_read(2'd3, d0, d2); sb_push("rst_hold_cap", 0, d2);
    sb_push("rst_hold_irq", 0, {31'b0, irq0 | irq2});
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1);
      bus_read(2'd0, d0, d2); sb_push("arm_data", (k >= 1) ? 32'hFF : 32'h0, d0);
      bus_read(2'd3, d0, d2);
      sb_push("arm_cap0", 0, d0); sb_push("arm_cap2", 0, d2);
      sb_push("arm_irq", 0, {31'b0, irq0 | irq2});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin fails++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_rise_irq;
    logic [31:0] d0, d2, o;
    exp_t e;
    in_port = 8'h00;
    step(4);
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h01);
    bus_read(2'd3, d0, d2); sb_push("rise_pre_cap", 0, d0);
    in_port = 8'h01;
    for (int k = 0; k < 4; k++) begin
      step(1);
      bus_read(2'd0, d0, d2); sb_push("rise_data", (k >= 1) ? 32'h01 : 32'h0, d0);
      bus_read(2'd3, d0, d2); sb_push("rise_cap", (k >= 2) ? 32'h01 : 32'h0, d0);
      sb_push("rise_irq", (k >= 2) ? 32'h1 : 32'h0, {31'b0, irq0});
    end
    bus_write(2'd3, 32'h01);
    bus_read(2'd3, d0, d2); sb_push("w1c_cap", 0, d0);
    sb_push("w1c_irq", 0, {31'b0, irq0});
    step(1);
    sb_push("w1c_irq_later", 0, {31'b0, irq0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin fails++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_w1c_collision;
    logic [31:0] d0, d2, o;
    exp_t e;
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h08);
    in_port = 8'h09;
    @(posedge clk);
    step(1);
    bus_read(2'd3, d0, d2); sb_push("coll_pre_cap", 0, d0);
    bus_write(2'd3, 32'h08);
    bus_read(2'd3, d0, d2); sb_push("coll_cap", 32'h08, d0);
    sb_push("coll_irq", 1, {31'b0, irq0});
    step(1);
    bus_read(2'd3, d0, d2); sb_push("coll_cap_hold", 32'h08, d0);
    bus_write(2'd3, 32'h08);
    bus_read(2'd3, d0, d2); sb_push("coll_clr_cap", 0, d0);
    sb_push("coll_clr_irq", 0, {31'b0, irq0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin fails++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_any_edge;
    logic [31:0] d0, d2, o;
    exp_t e;
    in_port = 8'h29;
    step(4);
    bus_write(2'd3, 32'hFF);
    bus_write(2'd2, 32'h00);
    in_port = 8'h09;
    step(3);
    bus_read(2'd3, d0, d2);
    sb_push("any_fall_cap2", 32'h20, d2); sb_push("rise_only_fall_cap0", 0, d0);
    in_port = 8'h29;
    step(3);
    bus_read(2'd3, d0, d2);
    sb_push("any_rise_cap2", 32'h20, d2); sb_push("rise_only_rise_cap0", 32'h20, d0);
    sb_push("any_masked_irq", 0, {31'b0, irq2});
    bus_write(2'd2, 32'h20);
    sb_push("any_unmask_irq2", 1, {31'b0, irq2});
    sb_push("any_unmask_irq0", 1, {31'b0, irq0});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin fails++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_reg_access;
    logic [31:0] d0, d2, o;
    exp_t e;
    bus_write(2'd0, 32'hDEADBEEF);
    bus_write(2'd1, 32'hDEADBEEF);
    bus_read(2'd0, d0, d2);
    sb_push("ro_data0", 32'h29, d0); sb_push("ro_data2", 32'h29, d2);
    bus_read(2'd1, d0, d2); sb_push("rsvd_read", 0, d0 | d2);
    bus_write(2'd2, 32'hFFFFFF5A);
    bus_read(2'd2, d0, d2);
    sb_push("mask_rb0", 32'h5A, d0); sb_push("mask_rb2", 32'h5A, d2);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin fails++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d0, d2, o;
    exp_t e;
    bus_write(2'd2, 32'hFF);
    in_port = 8'hD6;
    step(4);
    bus_read(2'd3, d0, d2);
    sb_push("pre_rst_cap2", 32'hFF, d2); sb_push("pre_rst_cap0", 32'hF6, d0);
    sb_push("pre_rst_irq", 1, {31'b0, irq2});
    reset_n = 1'b0; in_port = 8'h29;
    step(1);
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], d0, d2); sb_push("mid_rst_rd", 0, d0 | d2);
    end
    sb_push("mid_rst_irq", 0, {31'b0, irq0 | irq2});
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step(1);
      bus_read(2'd0, d0, d2); sb_push("rearm_data", (k >= 1) ? 32'h29 : 32'h0, d2);
      bus_read(2'd3, d0, d2); sb_push("rearm_cap", 0, d0 | d2);
      bus_read(2'd2, d0, d2); sb_push("rearm_mask", 0, d0 | d2);
      sb_push("rearm_irq", 0, {31'b0, irq0 | irq2});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e.val) begin fails++; $display("FAIL %s: got %h expected %h", e.name, o, e.val); end
    end
  endtask

  initial begin
    test_reset();
    test_rise_irq();
    test_w1c_collision();
    test_any_edge();
    test_reg_access();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
